// File: rtl/pie_reader_tx.sv
// Reader-side PIE transmitter: delimiter, D0, RTcal, optional TRcal, then up to 64 data
// symbols sent MSB-first. All outputs are registered.
module pie_reader_tx #(
  parameter int unsigned DELIM_CYC = 24,
  parameter int unsigned TARI_CYC  = 12,
  parameter int unsigned D1_CYC    = 24,
  parameter int unsigned PW_CYC    = 6,
  parameter int unsigned RTCAL_CYC = 36,
  parameter int unsigned TRCAL_CYC = 72
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_preamble,
  input  logic [63:0] i_cmd,
  input  logic [6:0]  i_len,
  output logic        o_pie,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {StIdle, StDelim, StD0, StRtcal, StTrcal, StData} state_e;

  // Counter load values are "phase length - 1": a phase ends when the counter reads 0.
  localparam logic [7:0] DelimLd   = 8'(DELIM_CYC - 1);
  localparam logic [7:0] TariHiLd  = 8'(TARI_CYC - PW_CYC - 1);
  localparam logic [7:0] D1HiLd    = 8'(D1_CYC - PW_CYC - 1);
  localparam logic [7:0] RtcalHiLd = 8'(RTCAL_CYC - PW_CYC - 1);
  localparam logic [7:0] TrcalHiLd = 8'(TRCAL_CYC - PW_CYC - 1);
  localparam logic [7:0] PwLd      = 8'(PW_CYC - 1);

  state_e      state_q, state_d;
  logic        lo_q, lo_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [6:0]  bits_q, bits_d;
  logic [63:0] sr_q, sr_d;
  logic        pre_q, pre_d;
  logic        pie_q, pie_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [6:0]  len_sat;
  logic [6:0]  rem_bits;
  logic        next_bit;

  assign len_sat = (i_len > 7'd64) ? 7'd64 : i_len;

  // Bits still to send and the next bit once the current symbol ends.
  assign rem_bits = (state_q == StData) ? (bits_q - 7'd1) : bits_q;
  assign next_bit = (state_q == StData) ? sr_q[62] : sr_q[63];

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    sr_d    = sr_q;
    pre_d   = pre_q;
    pie_d   = pie_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q == StIdle) begin
      if (i_start) begin
        state_d = StDelim;
        lo_d    = 1'b0;
        cnt_d   = DelimLd;
        bits_d  = len_sat;
        sr_d    = i_cmd;
        pre_d   = i_preamble;
        pie_d   = 1'b0;
        busy_d  = 1'b1;
      end
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else if (state_q == StDelim) begin
      state_d = StD0;
      lo_d    = 1'b0;
      cnt_d   = TariHiLd;
      pie_d   = 1'b1;
    end else if (!lo_q) begin
      lo_d  = 1'b1;
      cnt_d = PwLd;
      pie_d = 1'b0;
    end else begin
      lo_d  = 1'b0;
      pie_d = 1'b1;
      if (state_q == StD0) begin
        state_d = StRtcal;
        cnt_d   = RtcalHiLd;
      end else if (state_q == StRtcal && pre_q) begin
        state_d = StTrcal;
        cnt_d   = TrcalHiLd;
      end else begin
        if (state_q == StData) begin
          bits_d = rem_bits;
          sr_d   = sr_q << 1;
        end
        if (rem_bits != 7'd0) begin
          state_d = StData;
          cnt_d   = next_bit ? D1HiLd : TariHiLd;
        end else begin
          state_d = StIdle;
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lo_q    <= 1'b0;
      cnt_q   <= 8'd0;
      bits_q  <= 7'd0;
      sr_q    <= 64'd0;
      pre_q   <= 1'b0;
      pie_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      sr_q    <= sr_d;
      pre_q   <= pre_d;
      pie_q   <= pie_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_pie  = pie_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_pie_reader_tx.sv
// Self-checking bench for pie_reader_tx: fixed vectors, handshake and reset sequences,
// and random frames against a waveform model built symbol by symbol.
module tb_pie_reader_tx;

  localparam int DELIM = 24;
  localparam int TARI  = 12;
  localparam int D1    = 24;
  localparam int PW    = 6;
  localparam int RTCAL = 36;
  localparam int TRCAL = 72;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic        i_preamble;
  logic [63:0] i_cmd;
  logic [6:0]  i_len;
  logic        o_pie;
  logic        o_busy;
  logic        o_done;

  always #5 clk = ~clk;

  pie_reader_tx #(
    .DELIM_CYC (DELIM),
    .TARI_CYC  (TARI),
    .D1_CYC    (D1),
    .PW_CYC    (PW),
    .RTCAL_CYC (RTCAL),
    .TRCAL_CYC (TRCAL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_preamble (i_preamble),
    .i_cmd      (i_cmd),
    .i_len      (i_len),
    .o_pie      (o_pie),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  typedef struct {
    bit          pre;
    logic [63:0] cmd;
    logic [6:0]  len;
    int          exp_done;
    string       name;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          exp_q[$];
  bit          nxt_pre;
  logic [63:0] nxt_cmd;
  logic [6:0]  nxt_len;

  function automatic int v2i(input logic b);
    if (b === 1'b1) return 1;
    if (b === 1'b0) return 0;
    return 2;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_sym(input int len);
    repeat (len - PW) exp_q.push_back(1'b1);
    repeat (PW) exp_q.push_back(1'b0);
  endtask

  // Expected o_pie for cycles 1..N after the start edge.
  task automatic build(input bit pre, input logic [63:0] cmd, input int len);
    int n;
    exp_q.delete();
    repeat (DELIM) exp_q.push_back(1'b0);
    push_sym(TARI);
    push_sym(RTCAL);
    if (pre) push_sym(TRCAL);
    n = (len > 64) ? 64 : len;
    for (int i = 0; i < n; i++) push_sym(cmd[63-i] ? D1 : TARI);
  endtask

  task automatic start_frame(input bit pre, input logic [63:0] cmd, input logic [6:0] len);
    @(negedge clk);
    i_start    = 1'b1;
    i_preamble = pre;
    i_cmd      = cmd;
    i_len      = len;
    @(posedge clk);
  endtask

  // Called right after the start edge; checks every cycle up to and including o_done.
  task automatic run_check(input string name, input int exp_done, input int pulse_at,
                           input int hold_from);
    int n = exp_q.size();
    int done_at = -1;
    int bad_cnt = 0;
    int bad_at = 0;
    logic [2:0] exp3, act3, bad_exp, bad_act;
    bad_exp = 3'b000;
    bad_act = 3'b000;
    for (int k = 1; k <= n + 20; k++) begin
      @(negedge clk);
      if (k == 1) i_start = 1'b0;
      if (pulse_at != 0 && k == pulse_at) begin
        i_start    = 1'b1;
        i_preamble = ~i_preamble;
        i_len      = 7'd9;
        i_cmd      = ~i_cmd;
      end
      if (pulse_at != 0 && k == pulse_at + 1) i_start = 1'b0;
      if (hold_from != 0 && k == hold_from) begin
        i_start    = 1'b1;
        i_preamble = nxt_pre;
        i_cmd      = nxt_cmd;
        i_len      = nxt_len;
      end
      exp3 = (k <= n) ? {exp_q[k-1], 2'b10} : 3'b101;
      act3 = {o_pie, o_busy, o_done};
      if (act3 !== exp3) begin
        if (bad_cnt == 0) begin
          bad_at  = k;
          bad_act = act3;
          bad_exp = exp3;
        end
        bad_cnt++;
      end
      if (o_done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    chk($sformatf("%s wave bad cycles (first @%0d pie/busy/done got %b want %b)",
                  name, bad_at, bad_act, bad_exp), bad_cnt, 0);
    chk({name, " done cycle vs model"}, done_at, n + 1);
    if (exp_done > 0) chk({name, " done cycle"}, done_at, exp_done);
  endtask

  vec_t tbl[7];

  initial begin
    int bad;
    tbl[0] = '{1'b0, 64'h0, 7'd1, 85, "fs_1bit"};
    tbl[1] = '{1'b1, 64'h0, 7'd0, 145, "pre_nodata"};
    tbl[2] = '{1'b0, 64'hA000_0000_0000_0000, 7'd4, 145, "mixed"};
    tbl[3] = '{1'b0, 64'h0, 7'd0, 73, "fs_nodata"};
    tbl[4] = '{1'b1, 64'h8000_0000_0000_0000, 7'd1, 169, "pre_bit1"};
    tbl[5] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 7'd127, 1609, "len_sat"};
    tbl[6] = '{1'b1, 64'h0, 7'd64, 913, "pre_len64"};

    rst_n      = 1'b1;
    i_start    = 1'b0;
    i_preamble = 1'b0;
    i_cmd      = 64'h0;
    i_len      = 7'd0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset pie", v2i(o_pie), 1);
    chk("reset busy", v2i(o_busy), 0);
    chk("reset done", v2i(o_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      build(tbl[i].pre, tbl[i].cmd, int'(tbl[i].len));
      start_frame(tbl[i].pre, tbl[i].cmd, tbl[i].len);
      run_check(tbl[i].name, tbl[i].exp_done, 0, 0);
    end

    // Mid-frame start pulse is ignored; start held across o_done chains a second frame.
    nxt_pre = 1'b0;
    nxt_cmd = 64'h8000_0000_0000_0000;
    nxt_len = 7'd1;
    build(1'b0, 64'h0, 0);
    start_frame(1'b0, 64'h0, 7'd0);
    run_check("hs_first", 73, 30, 70);
    build(nxt_pre, nxt_cmd, int'(nxt_len));
    run_check("hs_second", 97, 0, 0);

    repeat (15) begin
      bit          pre;
      logic [63:0] cmd;
      logic [6:0]  len;
      pre = 1'($urandom_range(0, 1));
      cmd = {$urandom, $urandom};
      len = 7'($urandom_range(0, 70));
      build(pre, cmd, int'(len));
      start_frame(pre, cmd, len);
      run_check($sformatf("rand pre=%0d len=%0d", pre, len), 0, 0, 0);
    end

    // Asynchronous reset in the middle of a preamble frame.
    start_frame(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 7'd10);
    @(negedge clk);
    i_start = 1'b0;
    repeat (49) @(negedge clk);
    chk("midframe busy", v2i(o_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async reset pie", v2i(o_pie), 1);
    chk("async reset busy", v2i(o_busy), 0);
    chk("async reset done", v2i(o_done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ({o_pie, o_busy, o_done} !== 3'b100) bad++;
    end
    chk("idle hold bad cycles", bad, 0);

    build(1'b0, 64'h0, 1);
    start_frame(1'b0, 64'h0, 7'd1);
    run_check("after_reset", 85, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
